// File: rtl/mesh_credit_alloc_if.sv
`default_nettype none
// ============================================================================
//  Module      : mesh_credit_alloc_if
//  Description : Port bundle between the MESH router input units, the credit
//                switch allocator and the downstream links.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mesh_credit_alloc_if #(
  parameter int N  = 5,
  parameter int CW = 3,
  parameter int SW = 3
);
  logic [N-1:0]  i_req        [0:N-1];  // per input: one-hot requested output
  logic          i_tail       [0:N-1];  // per input: head flit is a tail
  logic          i_credit     [0:N-1];  // per output: downstream freed a slot
  logic [SW-1:0] o_sel        [0:N-1];  // per output: granted input index
  logic          o_en         [0:N-1];  // per input: flit read this cycle
  logic          o_val        [0:N-1];  // per output: flit driven downstream
  logic [CW-1:0] o_credit_cnt [0:N-1];  // per output: current credit count

  modport master (
    output i_req, i_tail, i_credit,
    input  o_sel, o_en, o_val, o_credit_cnt
  );

  modport slave (
    input  i_req, i_tail, i_credit,
    output o_sel, o_en, o_val, o_credit_cnt
  );
endinterface
`default_nettype wire

// File: rtl/mesh_credit_alloc.sv
`default_nettype none
// ============================================================================
//  Module      : mesh_credit_alloc
//  Description : Credit-based switch allocator for the 5-port MESH crossbar.
//                Per output: round-robin arbiter over the inputs, gated by a
//                downstream credit counter, with an optional wormhole lock.
//                Grants are combinational (same cycle as the request).
//  Config      : `define MESH_ALLOC_WORMHOLE_EN to hold an output for a whole
//                packet; undefined, every flit is arbitrated on its own.
//  Revision    : 1.0 - initial release
// ============================================================================
module mesh_credit_alloc #(
  parameter int N       = 5,
  parameter int CREDITS = 4,
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  wire logic          clk,
  input  wire logic          reset,
  mesh_credit_alloc_if.slave bus
);

  localparam int            SW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_CMAX = CW'(CREDITS);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [SW:0]   C_NW   = (SW+1)'(N);

`ifdef MESH_ALLOC_WORMHOLE_EN
  typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} lock_e;
`endif

  logic [N-1:0] req_lo [N];  // per input: lowest requested output only
  logic [N-1:0] gnt    [N];  // gnt[j][i]: output j granted to input i

  // Multi-hot requests collapse to their lowest output index
  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_lo[i] = bus.i_req[i] & (-bus.i_req[i]);
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_out
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  elig;
    logic [N-1:0]  rot;
    logic [SW-1:0] off, gidx, gnext;
    logic [SW:0]   sum, sumn;
    logic          any;
`ifdef MESH_ALLOC_WORMHOLE_EN
    lock_e         state_q, state_d;
    logic [SW-1:0] owner_q, owner_d;
`endif

    // Eligible requesters: need a credit, no reset, and lock ownership
    always_comb begin
      elig = '0;
      for (int i = 0; i < N; i++) begin
        elig[i] = req_lo[i][j] && (cnt_q != '0) && !reset;
`ifdef MESH_ALLOC_WORMHOLE_EN
        if (state_q == S_LOCKED && owner_q != i[SW-1:0]) elig[i] = 1'b0;
`endif
      end
    end

    // Round-robin pick: rotate so ptr sits at bit 0, take the lowest set bit
    always_comb begin
      rot = N'({elig, elig} >> ptr_q);
      off = '0;
      for (int b = N - 1; b >= 0; b--) begin
        if (rot[b]) off = b[SW-1:0];
      end
      any  = |elig;
      sum  = {1'b0, ptr_q} + {1'b0, off};
      if (sum >= C_NW) sum = sum - C_NW;
      gidx = sum[SW-1:0];
      sumn = {1'b0, gidx} + (SW+1)'(1);
      if (sumn >= C_NW) sumn = '0;
      gnext = sumn[SW-1:0];
    end

    // Credit spend/refund with saturation, and pointer advance past the winner
    always_comb begin
      cnt_d = cnt_q;
      if (bus.i_credit[j] && !any) begin
        if (cnt_q != C_CMAX) cnt_d = cnt_q + C_ONE;
      end else if (!bus.i_credit[j] && any) begin
        cnt_d = cnt_q - C_ONE;
      end
      ptr_d = ptr_q;
`ifdef MESH_ALLOC_WORMHOLE_EN
      if (any && state_q == S_IDLE) ptr_d = gnext;
`else
      if (any) ptr_d = gnext;
`endif
    end

    // Credit counter and arbitration pointer registers
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= C_CMAX;
        ptr_q <= '0;
      end else begin
        cnt_q <= cnt_d;
        ptr_q <= ptr_d;
      end
    end

`ifdef MESH_ALLOC_WORMHOLE_EN
    // Lock next-state: a non-tail grant claims the output until the owner's tail
    always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      case (state_q)
        S_IDLE: begin
          if (any && !bus.i_tail[gidx]) begin
            state_d = S_LOCKED;
            owner_d = gidx;
          end
        end
        S_LOCKED: begin
          if (any && bus.i_tail[gidx]) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Lock state and owner registers
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= S_IDLE;
        owner_q <= '0;
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
      end
    end
`endif

    assign gnt[j]              = any ? (N'(1) << gidx) : '0;
    assign bus.o_val[j]        = any;
    assign bus.o_sel[j]        = any ? gidx : '0;
    assign bus.o_credit_cnt[j] = cnt_q;
  end

  for (genvar i = 0; i < N; i++) begin : g_in
    logic en;
    // An input is read when any output granted it
    always_comb begin
      en = 1'b0;
      for (int j = 0; j < N; j++) begin
        en = en | gnt[j][i];
      end
    end
    assign bus.o_en[i] = en;
  end

`ifndef MESH_ALLOC_WORMHOLE_EN
  // Tail flags only matter to the wormhole lock
  logic unused_tail;
  always_comb begin
    unused_tail = 1'b0;
    for (int i = 0; i < N; i++) begin
      unused_tail = unused_tail ^ bus.i_tail[i];
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mesh_credit_alloc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mesh_credit_alloc
//  Description : Directed, table-driven bench for mesh_credit_alloc, with
//                hand-written sequences for credit exhaustion and reset
//                in the middle of a packet.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mesh_credit_alloc;
  localparam int N = 5, CREDITS = 4, CW = 3, SW = 3;

  typedef logic [N-1:0][N-1:0]  req_t;
  typedef logic [N-1:0][SW-1:0] sel_t;
  typedef logic [N-1:0][CW-1:0] cnt_t;

  typedef struct packed {
    req_t         req;
    logic [N-1:0] tail;
    logic [N-1:0] credit;
    logic         rst;
    logic [N-1:0] val;
    logic [N-1:0] en;
    sel_t         sel;
    cnt_t         cnt;
  } vec_t;

  localparam cnt_t C4 = {N{3'd4}};

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl[$];

  mesh_credit_alloc_if #(.N(N), .CW(CW), .SW(SW)) bus ();

  mesh_credit_alloc #(.N(N), .CREDITS(CREDITS)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(req_t req, logic [N-1:0] tail, logic [N-1:0] credit, logic rst,
                              logic [N-1:0] val, logic [N-1:0] en, sel_t sel, cnt_t cnt);
    vec_t v;
    v.req = req; v.tail = tail; v.credit = credit; v.rst = rst;
    v.val = val; v.en = en; v.sel = sel; v.cnt = cnt;
    return v;
  endfunction

  function automatic req_t rq(int i, int outj);
    req_t r;
    r = '0;
    r[i][outj] = 1'b1;
    return r;
  endfunction

  function automatic sel_t sl(int j, int v);
    sel_t r;
    r = '0;
    r[j] = v[SW-1:0];
    return r;
  endfunction

  function automatic cnt_t cw(int j, int v);
    cnt_t r;
    r = C4;
    r[j] = v[CW-1:0];
    return r;
  endfunction

  task automatic drive(req_t req, logic [N-1:0] tail, logic [N-1:0] credit, logic rst);
    @(negedge clk);
    reset = rst;
    for (int i = 0; i < N; i++) begin
      bus.i_req[i]    = req[i];
      bus.i_tail[i]   = tail[i];
      bus.i_credit[i] = credit[i];
    end
    #1;
  endtask

  task automatic sample(output logic [N-1:0] v, output logic [N-1:0] e,
                        output sel_t s, output cnt_t c);
    for (int j = 0; j < N; j++) begin
      v[j] = bus.o_val[j];
      e[j] = bus.o_en[j];
      s[j] = bus.o_sel[j];
      c[j] = bus.o_credit_cnt[j];
    end
  endtask

  task automatic chk(string nm, int row, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (row %0d): got %h, want %h", nm, row, act, exp);
    end
  endtask

  task automatic apply_row(vec_t t, int row);
    logic [N-1:0] v, e;
    sel_t s;
    cnt_t c;
    drive(t.req, t.tail, t.credit, t.rst);
    sample(v, e, s, c);
    chk("o_val", row, 32'(v), 32'(t.val));
    chk("o_en", row, 32'(e), 32'(t.en));
    chk("o_sel", row, 32'(s), 32'(t.sel));
    chk("o_credit_cnt", row, 32'(c), 32'(t.cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t         t2, t4;
    cnt_t         ctmp;
    logic [N-1:0] v, e;
    sel_t         s;
    cnt_t         c;
    int           g;

    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      bus.i_req[i] = '0; bus.i_tail[i] = 1'b0; bus.i_credit[i] = 1'b0;
    end

    // Reset state
    apply_row(mk('0, '0, '0, 1'b1, '0, '0, '0, C4), 900);
    apply_row(mk('0, '0, '0, 1'b1, '0, '0, '0, C4), 901);

    // Single request: input 1 -> output 2
    tbl.push_back(mk(rq(1, 2), 5'b00010, '0, 1'b0, 5'b00100, 5'b00010, sl(2, 1), C4));
    tbl.push_back(mk('0, '0, '0, 1'b0, '0, '0, '0, cw(2, 3)));
    // Fair arbitration: inputs 0,3,4 -> output 0, credit every cycle
    t2 = rq(0, 0) | rq(3, 0) | rq(4, 0);
    tbl.push_back(mk(t2, 5'b11001, 5'b00001, 1'b0, 5'b00001, 5'b00001, sl(0, 0), cw(2, 3)));
    tbl.push_back(mk(t2, 5'b11001, 5'b00001, 1'b0, 5'b00001, 5'b01000, sl(0, 3), cw(2, 3)));
    tbl.push_back(mk(t2, 5'b11001, 5'b00001, 1'b0, 5'b00001, 5'b10000, sl(0, 4), cw(2, 3)));
    tbl.push_back(mk(t2, 5'b11001, 5'b00001, 1'b0, 5'b00001, 5'b00001, sl(0, 0), cw(2, 3)));
    tbl.push_back(mk(t2, 5'b11001, 5'b00001, 1'b0, 5'b00001, 5'b01000, sl(0, 3), cw(2, 3)));
    tbl.push_back(mk('0, '0, 5'b00100, 1'b0, '0, '0, '0, cw(2, 3)));
    // Credit corners on output 1
    tbl.push_back(mk(rq(0, 1), 5'b00001, '0, 1'b0, 5'b00010, 5'b00001, sl(1, 0), C4));
    tbl.push_back(mk(rq(0, 1), 5'b00001, '0, 1'b0, 5'b00010, 5'b00001, sl(1, 0), cw(1, 3)));
    tbl.push_back(mk(rq(0, 1), 5'b00001, 5'b00010, 1'b0, 5'b00010, 5'b00001, sl(1, 0), cw(1, 2)));
    tbl.push_back(mk('0, '0, '0, 1'b0, '0, '0, '0, cw(1, 2)));
    tbl.push_back(mk('0, '0, 5'b00010, 1'b0, '0, '0, '0, cw(1, 2)));
    tbl.push_back(mk('0, '0, 5'b00010, 1'b0, '0, '0, '0, cw(1, 3)));
    tbl.push_back(mk('0, '0, 5'b00010, 1'b0, '0, '0, '0, C4));
    tbl.push_back(mk('0, '0, '0, 1'b0, '0, '0, '0, C4));
    // Wormhole: move ptr[4] to 1, then input 2 sends 3 flits while input 0 competes
    tbl.push_back(mk(rq(0, 4), 5'b00001, 5'b10000, 1'b0, 5'b10000, 5'b00001, sl(4, 0), C4));
    t4 = rq(0, 4) | rq(2, 4);
`ifdef MESH_ALLOC_WORMHOLE_EN
    tbl.push_back(mk(t4, 5'b00001, 5'b10000, 1'b0, 5'b10000, 5'b00100, sl(4, 2), C4));
    tbl.push_back(mk(t4, 5'b00001, 5'b10000, 1'b0, 5'b10000, 5'b00100, sl(4, 2), C4));
    tbl.push_back(mk(t4, 5'b00101, 5'b10000, 1'b0, 5'b10000, 5'b00100, sl(4, 2), C4));
    tbl.push_back(mk(rq(0, 4), 5'b00001, 5'b10000, 1'b0, 5'b10000, 5'b00001, sl(4, 0), C4));
`else
    tbl.push_back(mk(t4, 5'b00001, 5'b10000, 1'b0, 5'b10000, 5'b00100, sl(4, 2), C4));
    tbl.push_back(mk(t4, 5'b00001, 5'b10000, 1'b0, 5'b10000, 5'b00001, sl(4, 0), C4));
    tbl.push_back(mk(t4, 5'b00001, 5'b10000, 1'b0, 5'b10000, 5'b00100, sl(4, 2), C4));
    tbl.push_back(mk(t4, 5'b00101, 5'b10000, 1'b0, 5'b10000, 5'b00001, sl(4, 0), C4));
    tbl.push_back(mk(t4, 5'b00101, 5'b10000, 1'b0, 5'b10000, 5'b00100, sl(4, 2), C4));
`endif
    tbl.push_back(mk('0, '0, '0, 1'b0, '0, '0, '0, C4));

    foreach (tbl[k]) apply_row(tbl[k], k);

    // Credit exhaustion: input 0 streams tail flits to output 1 with no credits
    g = 0;
    for (int k = 0; k < 8; k++) begin
      drive(rq(0, 1), 5'b00001, '0, 1'b0);
      sample(v, e, s, c);
      if (v[1]) g++;
    end
    chk("exhaust_grants", 100, 32'(g), 32'd4);
    chk("exhaust_cnt", 100, 32'(c[1]), 32'd0);
    drive(rq(0, 1), 5'b00001, 5'b00010, 1'b0);
    sample(v, e, s, c);
    chk("exhaust_no_grant_at_zero", 101, 32'(v[1]), 32'd0);
    g = 0;
    for (int k = 0; k < 4; k++) begin
      drive(rq(0, 1), 5'b00001, '0, 1'b0);
      sample(v, e, s, c);
      if (v[1]) g++;
    end
    chk("exhaust_one_more", 102, 32'(g), 32'd1);
    chk("exhaust_cnt_after", 102, 32'(c[1]), 32'd0);

    // Reset in the middle of a packet from input 2 to output 4
    apply_row(mk(rq(2, 4), 5'b00000, '0, 1'b0, 5'b10000, 5'b00100, sl(4, 2), cw(1, 0)), 200);
    ctmp = cw(1, 0);
    ctmp[4] = 3'd3;
    apply_row(mk(t4, 5'b00001, '0, 1'b1, '0, '0, '0, ctmp), 201);
    apply_row(mk(t4, 5'b00001, '0, 1'b1, '0, '0, '0, C4), 202);
    apply_row(mk(t4, 5'b00001, '0, 1'b0, 5'b10000, 5'b00001, sl(4, 0), C4), 203);
    apply_row(mk('0, '0, '0, 1'b0, '0, '0, '0, cw(4, 3)), 204);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
